mms_stream_nnum: RTL and testbench

- Streaming min/max selector: accepts a frame of SIZE numbers serially over a valid/ready input handshake.
- Returns the frame minimum or maximum, plus its position in the frame, over a valid/ready output handshake.
- Parametrised successor of the fixed 8×8-bit combinational min/max selector. Adds width/depth generalisation, a signed mode, index reporting, back-pressure and frame flush.
- Sits between a sample source and downstream consumers in the hw1 datapath.

---
 rtl/mms_pkg.sv | 12 +
 rtl/mms_stream_nnum_if.sv | 26 ++
 rtl/mms_better_cmp.sv | 29 ++
 rtl/mms_stream_nnum.sv | 122 ++++++++++++
 tb/tb_mms_stream_nnum.sv | 296 +++++++++++++++++++++++++++++
 5 files changed

// File: rtl/mms_pkg.sv
// Shared constants and helpers for the streaming min/max selector.
package mms_pkg;

  localparam logic SEL_MAX = 1'b0;
  localparam logic SEL_MIN = 1'b1;

  // Index/count width for a frame of `size` elements, never narrower than 1 bit.
  function automatic int idx_w(input int size);
    return (size <= 1) ? 1 : $clog2(size);
  endfunction

endpackage

// File: rtl/mms_stream_nnum_if.sv
// Input element handshake and output result handshake of the min/max selector.
interface mms_stream_nnum_if #(
  parameter int WIDTH = 8,
  parameter int IDX_W = 3
);
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] in_data;
  logic             select;
  logic             flush;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] result;
  logic [IDX_W-1:0] result_idx;
  logic             frame_sel;

  modport slave (
    input  in_valid, in_data, select, flush, out_ready,
    output in_ready, out_valid, result, result_idx, frame_sel
  );

  modport master (
    output in_valid, in_data, select, flush, out_ready,
    input  in_ready, out_valid, result, result_idx, frame_sel
  );
endinterface

// File: rtl/mms_better_cmp.sv
// Strict "b beats a" compare: greater for max frames, smaller for min frames.
module mms_better_cmp
  import mms_pkg::*;
#(
  parameter int WIDTH  = 8,
  parameter int SIGNED = 0
) (
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             sel,
  output logic             b_better
);

  logic gt;
  logic lt;

  always_comb begin
    if (SIGNED != 0) begin
      gt = $signed(b) > $signed(a);
      lt = $signed(b) < $signed(a);
    end else begin
      gt = b > a;
      lt = b < a;
    end
    // Strict compare keeps the earliest element on ties.
    b_better = (sel == SEL_MIN) ? lt : gt;
  end

endmodule

// File: rtl/mms_stream_nnum.sv
// Streaming min/max selector: folds a SIZE-element frame into one result with
// its in-frame position; the last element stalls only while a result is pending.
module mms_stream_nnum
  import mms_pkg::*;
#(
  parameter int WIDTH  = 8,
  parameter int SIZE   = 8,
  parameter int SIGNED = 0,
  parameter int IDX_W  = idx_w(SIZE)
) (
  input  logic                 clk,
  input  logic                 reset,
  mms_stream_nnum_if.slave     s
);

  localparam logic [IDX_W-1:0] LAST = IDX_W'(SIZE - 1);

  logic [IDX_W-1:0] cnt_q, cnt_d;
  logic [WIDTH-1:0] acc_q, acc_d;
  logic [IDX_W-1:0] acc_idx_q, acc_idx_d;
  logic             sel_q, sel_d;
  logic [WIDTH-1:0] res_q, res_d;
  logic [IDX_W-1:0] res_idx_q, res_idx_d;
  logic             fsel_q, fsel_d;
  logic             ov_q, ov_d;

  logic is_first;
  logic is_last;
  logic in_ready;
  logic accept;
  logic b_better;

  assign is_first = (cnt_q == '0);
  assign is_last  = (cnt_q == LAST);
  assign in_ready = !(ov_q && is_last);
  assign accept   = s.in_valid && in_ready;

  mms_better_cmp #(
    .WIDTH  (WIDTH),
    .SIGNED (SIGNED)
  ) u_cmp (
    .a        (acc_q),
    .b        (s.in_data),
    .sel      (sel_q),
    .b_better (b_better)
  );

  always_comb begin
    cnt_d     = cnt_q;
    acc_d     = acc_q;
    acc_idx_d = acc_idx_q;
    sel_d     = sel_q;
    res_d     = res_q;
    res_idx_d = res_idx_q;
    fsel_d    = fsel_q;
    ov_d      = ov_q;

    if (ov_q && s.out_ready) begin
      ov_d = 1'b0;
    end

    if (s.flush) begin
      cnt_d = '0;
    end else if (accept) begin
      if (is_last) begin
        // A one-element frame has no accumulator; the element is the result.
        if (is_first) begin
          sel_d     = s.select;
          res_d     = s.in_data;
          res_idx_d = '0;
          fsel_d    = s.select;
        end else begin
          res_d     = b_better ? s.in_data : acc_q;
          res_idx_d = b_better ? cnt_q : acc_idx_q;
          fsel_d    = sel_q;
        end
        ov_d  = 1'b1;
        cnt_d = '0;
      end else if (is_first) begin
        sel_d     = s.select;
        acc_d     = s.in_data;
        acc_idx_d = '0;
        cnt_d     = cnt_q + 1'b1;
      end else begin
        if (b_better) begin
          acc_d     = s.in_data;
          acc_idx_d = cnt_q;
        end
        cnt_d = cnt_q + 1'b1;
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cnt_q     <= '0;
      acc_q     <= '0;
      acc_idx_q <= '0;
      sel_q     <= 1'b0;
      res_q     <= '0;
      res_idx_q <= '0;
      fsel_q    <= 1'b0;
      ov_q      <= 1'b0;
    end else begin
      cnt_q     <= cnt_d;
      acc_q     <= acc_d;
      acc_idx_q <= acc_idx_d;
      sel_q     <= sel_d;
      res_q     <= res_d;
      res_idx_q <= res_idx_d;
      fsel_q    <= fsel_d;
      ov_q      <= ov_d;
    end
  end

  assign s.in_ready   = in_ready;
  assign s.out_valid  = ov_q;
  assign s.result     = res_q;
  assign s.result_idx = res_idx_q;
  assign s.frame_sel  = fsel_q;

endmodule

// File: tb/tb_mms_stream_nnum.sv
// Bench for mms_stream_nnum: unsigned and signed 8x8 instances share one stimulus
// stream and a frame-level reference model; a WIDTH=12/SIZE=1 instance is checked directly.
module tb_mms_stream_nnum;
  import mms_pkg::*;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_err    = 0;

  mms_stream_nnum_if #(.WIDTH(8),  .IDX_W(3)) ifu ();
  mms_stream_nnum_if #(.WIDTH(8),  .IDX_W(3)) ifs ();
  mms_stream_nnum_if #(.WIDTH(12), .IDX_W(1)) ifw ();

  mms_stream_nnum #(.WIDTH(8), .SIZE(8), .SIGNED(0)) u_uns (.clk(clk), .reset(rst), .s(ifu.slave));
  mms_stream_nnum #(.WIDTH(8), .SIZE(8), .SIGNED(1)) u_sgn (.clk(clk), .reset(rst), .s(ifs.slave));
  mms_stream_nnum #(.WIDTH(12), .SIZE(1), .SIGNED(0)) u_w12 (.clk(clk), .reset(rst), .s(ifw.slave));

  assign ifs.in_valid  = ifu.in_valid;
  assign ifs.in_data   = ifu.in_data;
  assign ifs.select    = ifu.select;
  assign ifs.flush     = ifu.flush;
  assign ifs.out_ready = ifu.out_ready;

  task automatic chk(input string nm, input int act, input int exp);
    n_checks++;
    if (act != exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
    end
  endtask

  function automatic int val(input int r, input bit sgn);
    logic [7:0] t;
    t = r[7:0];
    return sgn ? int'($signed(t)) : int'(t);
  endfunction

  // Position of the best element of a frame; the first occurrence wins ties.
  function automatic int best_idx(input int raw[8], input bit sgn, input bit mn);
    int b = 0;
    for (int i = 1; i < 8; i++) begin
      if (mn ? (val(raw[i], sgn) < val(raw[b], sgn)) : (val(raw[i], sgn) > val(raw[b], sgn)))
        b = i;
    end
    return b;
  endfunction

  // Reference model, evaluated at each falling edge for the coming rising edge.
  int fn;
  int fraw[8];
  bit fsel;
  bit pv;
  int pres[2];
  int pidx[2];
  bit psel;
  bit exp_rdy;
  bit newres;
  int bi;

  always @(negedge clk) begin
    if (rst) begin
      fn = 0;
      pv = 1'b0;
    end else begin
      exp_rdy = !(pv && fn == 7);
      chk("u_in_ready", ifu.in_ready, exp_rdy);
      chk("s_in_ready", ifs.in_ready, exp_rdy);
      chk("u_out_valid", ifu.out_valid, pv);
      chk("s_out_valid", ifs.out_valid, pv);
      if (pv) begin
        chk("u_result", ifu.result, pres[0]);
        chk("u_result_idx", ifu.result_idx, pidx[0]);
        chk("u_frame_sel", ifu.frame_sel, psel);
        chk("s_result", ifs.result, pres[1]);
        chk("s_result_idx", ifs.result_idx, pidx[1]);
        chk("s_frame_sel", ifs.frame_sel, psel);
      end
      newres = 1'b0;
      if (ifu.flush) begin
        fn = 0;
      end else if (ifu.in_valid && exp_rdy) begin
        if (fn == 0) fsel = ifu.select;
        fraw[fn] = int'(ifu.in_data);
        fn++;
        if (fn == 8) begin
          for (int m = 0; m < 2; m++) begin
            bi = best_idx(fraw, m == 1, fsel);
            pres[m] = fraw[bi];
            pidx[m] = bi;
          end
          psel   = fsel;
          pv     = 1'b1;
          newres = 1'b1;
          fn     = 0;
        end
      end
      if (!newres && pv && ifu.out_ready) pv = 1'b0;
    end
  end

  typedef struct {
    logic [7:0] d[8];
    logic       sel;
    int         ures;
    int         uidx;
    int         sres;
    int         sidx;
  } vec_t;

  vec_t tbl[5];

  task automatic push(input logic [7:0] d, input logic sel);
    bit done = 1'b0;
    ifu.in_valid = 1'b1;
    ifu.in_data  = d;
    ifu.select   = sel;
    for (int k = 0; k < 50 && !done; k++) begin
      @(negedge clk);
      done = ifu.in_ready;
      @(posedge clk);
      #1;
    end
    chk("push_accept", done, 1);
    ifu.in_valid = 1'b0;
  endtask

  task automatic send_frame(input logic [7:0] d[8], input logic sel, input int n);
    for (int i = 0; i < n; i++) push(d[i], sel);
  endtask

  task automatic push_w(input logic [11:0] d, input logic sel);
    bit done = 1'b0;
    ifw.in_valid = 1'b1;
    ifw.in_data  = d;
    ifw.select   = sel;
    for (int k = 0; k < 50 && !done; k++) begin
      @(negedge clk);
      done = ifw.in_ready;
      @(posedge clk);
      #1;
    end
    chk("w_push_accept", done, 1);
    ifw.in_valid = 1'b0;
  endtask

  task automatic chk_reset_outputs(input string tag);
    chk({tag, "_u_out_valid"}, ifu.out_valid, 0);
    chk({tag, "_u_result"}, ifu.result, 0);
    chk({tag, "_u_result_idx"}, ifu.result_idx, 0);
    chk({tag, "_u_frame_sel"}, ifu.frame_sel, 0);
    chk({tag, "_u_in_ready"}, ifu.in_ready, 1);
    chk({tag, "_s_out_valid"}, ifs.out_valid, 0);
    chk({tag, "_s_result"}, ifs.result, 0);
    chk({tag, "_w_out_valid"}, ifw.out_valid, 0);
    chk({tag, "_w_result"}, ifw.result, 0);
  endtask

  bit stalled;

  initial begin
    tbl[0].d = '{8'd3, 8'd200, 8'd17, 8'd200, 8'd5, 8'd0, 8'd99, 8'd1};
    tbl[0].sel = SEL_MAX; tbl[0].ures = 200; tbl[0].uidx = 1; tbl[0].sres = 99;  tbl[0].sidx = 6;
    tbl[1].d = '{8'd5, 8'hFD, 8'h7F, 8'h80, 8'd0, 8'h80, 8'd1, 8'd2};
    tbl[1].sel = SEL_MIN; tbl[1].ures = 0;   tbl[1].uidx = 4; tbl[1].sres = 128; tbl[1].sidx = 3;
    tbl[2].d = '{8'd10, 8'd20, 8'd30, 8'd40, 8'd50, 8'd60, 8'd70, 8'd80};
    tbl[2].sel = SEL_MIN; tbl[2].ures = 10;  tbl[2].uidx = 0; tbl[2].sres = 10;  tbl[2].sidx = 0;
    tbl[3].d = '{8'h55, 8'h55, 8'h55, 8'h55, 8'h55, 8'h55, 8'h55, 8'h55};
    tbl[3].sel = SEL_MAX; tbl[3].ures = 85;  tbl[3].uidx = 0; tbl[3].sres = 85;  tbl[3].sidx = 0;
    tbl[4].d = '{8'h80, 8'h7F, 8'd1, 8'd2, 8'd3, 8'd4, 8'd5, 8'hFF};
    tbl[4].sel = SEL_MAX; tbl[4].ures = 255; tbl[4].uidx = 7; tbl[4].sres = 127; tbl[4].sidx = 1;

    rst = 1'b1;
    ifu.in_valid = 1'b0; ifu.in_data = '0; ifu.select = 1'b0; ifu.flush = 1'b0; ifu.out_ready = 1'b1;
    ifw.in_valid = 1'b0; ifw.in_data = '0; ifw.select = 1'b0; ifw.flush = 1'b0; ifw.out_ready = 1'b1;
    #2;
    chk_reset_outputs("por");
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;

    for (int i = 0; i < 5; i++) begin
      send_frame(tbl[i].d, tbl[i].sel, 8);
      @(negedge clk);
      chk("tbl_u_valid", ifu.out_valid, 1);
      chk("tbl_u_result", ifu.result, tbl[i].ures);
      chk("tbl_u_idx", ifu.result_idx, tbl[i].uidx);
      chk("tbl_u_sel", ifu.frame_sel, tbl[i].sel);
      chk("tbl_s_result", ifs.result, tbl[i].sres);
      chk("tbl_s_idx", ifs.result_idx, tbl[i].sidx);
      @(posedge clk); #1;
    end

    // Back-to-back frames against a stalled consumer.
    ifu.out_ready = 1'b0;
    send_frame(tbl[0].d, tbl[0].sel, 8);
    send_frame(tbl[2].d, tbl[2].sel, 7);
    ifu.in_valid = 1'b1; ifu.in_data = 8'd80; ifu.select = SEL_MIN;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      chk("b2b_stall_in_ready", ifu.in_ready, 0);
      chk("b2b_hold_valid", ifu.out_valid, 1);
      chk("b2b_hold_result", ifu.result, 200);
      chk("b2b_hold_idx", ifu.result_idx, 1);
      chk("b2b_hold_s_result", ifs.result, 99);
      @(posedge clk); #1;
    end
    ifu.out_ready = 1'b1;
    @(negedge clk);
    chk("b2b_no_comb_ready", ifu.in_ready, 0);
    @(posedge clk); #1;
    ifu.out_ready = 1'b0;
    @(negedge clk);
    chk("b2b_drained_valid", ifu.out_valid, 0);
    chk("b2b_release_ready", ifu.in_ready, 1);
    @(posedge clk); #1;
    ifu.in_valid = 1'b0;
    @(negedge clk);
    chk("b2b_second_valid", ifu.out_valid, 1);
    chk("b2b_second_result", ifu.result, 10);
    chk("b2b_second_idx", ifu.result_idx, 0);
    chk("b2b_second_sel", ifu.frame_sel, 1);
    @(posedge clk); #1;
    ifu.out_ready = 1'b1;
    @(posedge clk); #1;

    // Flush a partial frame, including an element offered in the flush cycle.
    send_frame('{8'd1, 8'd2, 8'd3, 8'd4, 8'd0, 8'd0, 8'd0, 8'd0}, SEL_MAX, 4);
    ifu.in_valid = 1'b1; ifu.in_data = 8'd5; ifu.flush = 1'b1;
    @(posedge clk); #1;
    ifu.in_valid = 1'b0; ifu.flush = 1'b0;
    send_frame(tbl[2].d, tbl[2].sel, 8);
    @(negedge clk);
    chk("flush_result", ifu.result, 10);
    chk("flush_idx", ifu.result_idx, 0);
    chk("flush_sel", ifu.frame_sel, 1);
    @(posedge clk); #1;

    // Asynchronous reset with a pending result and a frame at cnt=5.
    ifu.out_ready = 1'b0;
    send_frame(tbl[3].d, tbl[3].sel, 8);
    send_frame(tbl[4].d, tbl[4].sel, 5);
    @(posedge clk);
    #3 rst = 1'b1;
    #1;
    chk_reset_outputs("async_rst");
    @(posedge clk); #1;
    rst = 1'b0;
    ifu.out_ready = 1'b1;
    send_frame(tbl[1].d, tbl[1].sel, 8);
    @(negedge clk);
    chk("post_rst_u_result", ifu.result, 0);
    chk("post_rst_u_idx", ifu.result_idx, 4);
    chk("post_rst_s_result", ifs.result, 128);
    chk("post_rst_s_idx", ifs.result_idx, 3);
    @(posedge clk); #1;

    // SIZE=1, WIDTH=12: every element is its own frame.
    push_w(12'hABC, SEL_MIN);
    @(negedge clk);
    chk("w_valid0", ifw.out_valid, 1);
    chk("w_result0", ifw.result, 12'hABC);
    chk("w_idx0", ifw.result_idx, 0);
    chk("w_sel0", ifw.frame_sel, 1);
    @(posedge clk); #1;
    push_w(12'h001, SEL_MAX);
    @(negedge clk);
    chk("w_valid1", ifw.out_valid, 1);
    chk("w_result1", ifw.result, 12'h001);
    chk("w_idx1", ifw.result_idx, 0);
    chk("w_sel1", ifw.frame_sel, 0);
    @(posedge clk); #1;

    // Random traffic with back-pressure and occasional flush.
    for (int c = 0; c < 3000; c++) begin
      @(negedge clk);
      stalled = ifu.in_valid && !ifu.in_ready;
      @(posedge clk); #1;
      if (!stalled) begin
        ifu.in_valid = ($urandom_range(9) < 7);
        ifu.in_data  = ($urandom_range(3) == 0) ? 8'h80 : 8'($urandom);
        ifu.select   = 1'($urandom);
      end
      ifu.out_ready = ($urandom_range(2) != 0);
      ifu.flush     = ($urandom_range(39) == 0);
    end
    ifu.in_valid = 1'b0; ifu.flush = 1'b0; ifu.out_ready = 1'b1;
    repeat (4) @(posedge clk);
    #1;

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
    $finish;
  end

endmodule
